// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage pipeline register with a 2-entry skid buffer.
// M drives the outputs and S absorbs one extra word under backpressure.
// A synchronous flush squashes held entries into NOPs, and a saturating
// counter records the cycles in which the consumer was ready but idle.
module pipe_stage_skid #(
    parameter int unsigned          CTRL_W   = 8,
    parameter logic [CTRL_W-1:0]    NOP_CTRL = '0,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          NUM_DATA = 3,
    parameter int unsigned          ADDR_W   = 5,
    parameter int unsigned          NUM_ADDR = 3,
    parameter int unsigned          CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0]   in_data,
    input  logic [NUM_ADDR*ADDR_W-1:0]   in_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0]   out_data,
    output logic [NUM_ADDR*ADDR_W-1:0]   out_addr,
    output logic [1:0]                   occupancy,
    output logic [CNT_W-1:0]             bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;

    logic [CTRL_W-1:0]            r_m_ctrl;
    logic [NUM_DATA*DATA_W-1:0]   r_m_data;
    logic [NUM_ADDR*ADDR_W-1:0]   r_m_addr;
    logic [CTRL_W-1:0]            r_s_ctrl;
    logic [NUM_DATA*DATA_W-1:0]   r_s_data;
    logic [NUM_ADDR*ADDR_W-1:0]   r_s_addr;
    logic [CNT_W-1:0]             r_bubble_cnt;

    logic                         w_accept;
    logic                         w_emit;
    logic                         w_load_m_in;
    logic                         w_load_m_s;
    logic                         w_load_s_in;

    // in_ready and out_valid decode only the state register, so neither
    // depends combinationally on in_valid or out_ready.
    assign in_ready   = (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_accept   = in_valid && in_ready;
    assign w_emit     = out_valid && out_ready;

    assign out_ctrl   = out_valid ? r_m_ctrl : NOP_CTRL;
    assign out_data   = r_m_data;
    assign out_addr   = r_m_addr;
    assign occupancy  = r_state;
    assign bubble_cnt = r_bubble_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and register-load selects; flush completes the handshake
    // but suppresses every load, so the accepted word is dropped.
    always_comb begin
        w_next_state = r_state;
        w_load_m_in  = 1'b0;
        w_load_m_s   = 1'b0;
        w_load_s_in  = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state = ST_ONE;
                    w_load_m_in  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_emit) begin
                    w_load_m_in  = 1'b1;
                end else if (w_accept) begin
                    w_next_state = ST_FULL;
                    w_load_s_in  = 1'b1;
                end else if (w_emit) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_emit) begin
                    w_next_state = ST_ONE;
                    w_load_m_s   = 1'b1;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
        if (flush) begin
            w_next_state = ST_EMPTY;
            w_load_m_in  = 1'b0;
            w_load_m_s   = 1'b0;
            w_load_s_in  = 1'b0;
        end
    end

    // Main and skid payload registers; loaded only on the selects above
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_ctrl <= '0;
            r_m_data <= '0;
            r_m_addr <= '0;
            r_s_ctrl <= '0;
            r_s_data <= '0;
            r_s_addr <= '0;
        end else begin
            if (w_load_m_in) begin
                r_m_ctrl <= in_ctrl;
                r_m_data <= in_data;
                r_m_addr <= in_addr;
            end else if (w_load_m_s) begin
                r_m_ctrl <= r_s_ctrl;
                r_m_data <= r_s_data;
                r_m_addr <= r_s_addr;
            end
            if (w_load_s_in) begin
                r_s_ctrl <= in_ctrl;
                r_s_data <= in_data;
                r_s_addr <= in_addr;
            end
        end
    end

    // Saturating bubble counter: consumer ready but nothing presented
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (out_ready && !out_valid && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid.
// A second instance with a 2-bit bubble counter checks saturation.
module tb_pipe_stage_skid;

    localparam int unsigned CTRL_W   = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_DATA = 3;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_ADDR = 3;

    logic                         clk = 1'b0;
    logic                         rst, flush, in_valid, out_ready;
    logic                         in_ready, out_valid;
    logic [CTRL_W-1:0]            in_ctrl, out_ctrl;
    logic [NUM_DATA*DATA_W-1:0]   in_data, out_data;
    logic [NUM_ADDR*ADDR_W-1:0]   in_addr, out_addr;
    logic [1:0]                   occupancy;
    logic [15:0]                  bubble_cnt;

    logic                         rst2, out_ready2;
    logic                         in_ready2, out_valid2;
    logic [CTRL_W-1:0]            out_ctrl2;
    logic [NUM_DATA*DATA_W-1:0]   out_data2;
    logic [NUM_ADDR*ADDR_W-1:0]   out_addr2;
    logic [1:0]                   occupancy2;
    logic [1:0]                   bubble_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .CTRL_W(CTRL_W), .NOP_CTRL(8'h00), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA),
        .ADDR_W(ADDR_W), .NUM_ADDR(NUM_ADDR), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_addr(out_addr), .occupancy(occupancy),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(
        .CTRL_W(CTRL_W), .NOP_CTRL(8'h00), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA),
        .ADDR_W(ADDR_W), .NUM_ADDR(NUM_ADDR), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst(rst2), .flush(1'b0), .in_valid(1'b0), .in_ready(in_ready2),
        .in_ctrl(8'h77), .in_data('0), .in_addr('0),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_ctrl(out_ctrl2),
        .out_data(out_data2), .out_addr(out_addr2), .occupancy(occupancy2),
        .bubble_cnt(bubble_cnt2)
    );

    // Advance one rising edge and settle before sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_DATA*DATA_W-1:0] mk_data(input logic [31:0] w0,
                                                         input logic [31:0] w1,
                                                         input logic [31:0] w2);
        return {w2, w1, w0};
    endfunction

    function automatic logic [NUM_ADDR*ADDR_W-1:0] mk_addr(input logic [4:0] a0,
                                                         input logic [4:0] a1,
                                                         input logic [4:0] a2);
        return {a2, a1, a0};
    endfunction

    task automatic drive(input logic v, input logic [7:0] c);
        in_valid = v;
        in_ctrl  = c;
        in_data  = mk_data(32'(c), 32'(c) + 32'd1, 32'(c) + 32'd2);
        in_addr  = mk_addr(c[4:0], c[4:0] + 5'd1, c[4:0] + 5'd2);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; drive(1'b0, 8'h00);
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bubble_cnt !== 16'd0) begin
            n_bad++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt);
        end
        n_cmp++;
        if (out_data !== '0 || out_addr !== '0) begin
            n_bad++; $display("FAIL reset_payload: got %h/%h want 0/0", out_data, out_addr);
        end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            n_bad++;
            $display("FAIL idle_outputs: got v=%b c=%h r=%b o=%0d want v=0 c=00 r=1 o=0",
                     out_valid, out_ctrl, in_ready, occupancy);
        end
        n_cmp++;
        if (bubble_cnt !== 16'd5) begin
            n_bad++; $display("FAIL idle_bubble: got %0d want 5", bubble_cnt);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid = 1'b1; in_ctrl = 8'hA5;
        in_data = mk_data(32'd1, 32'd2, 32'd3); in_addr = mk_addr(5'd4, 5'd5, 5'd6);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ctrl !== 8'hA5 || out_data !== mk_data(32'd1, 32'd2, 32'd3)
            || out_addr !== mk_addr(5'd4, 5'd5, 5'd6)) begin
            n_bad++;
            $display("FAIL stream_first: got v=%b c=%h d=%h a=%h want v=1 c=a5 d=%h a=%h",
                     out_valid, out_ctrl, out_data, out_addr,
                     mk_data(32'd1, 32'd2, 32'd3), mk_addr(5'd4, 5'd5, 5'd6));
        end
        in_ctrl = 8'h5A;
        in_data = mk_data(32'd7, 32'd8, 32'd9); in_addr = mk_addr(5'd10, 5'd11, 5'd12);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ctrl !== 8'h5A || out_data !== mk_data(32'd7, 32'd8, 32'd9)
            || out_addr !== mk_addr(5'd10, 5'd11, 5'd12) || occupancy !== 2'd1) begin
            n_bad++;
            $display("FAIL stream_second: got v=%b c=%h d=%h a=%h o=%0d want v=1 c=5a o=1",
                     out_valid, out_ctrl, out_data, out_addr, occupancy);
        end
        drive(1'b0, 8'h00);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
            n_bad++; $display("FAIL stream_drain: got v=%b c=%h want v=0 c=00", out_valid, out_ctrl);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] seen [$];
        logic [7:0] want [3];
        want[0] = 8'h21; want[1] = 8'h22; want[2] = 8'h23;
        out_ready = 1'b1; drive(1'b1, 8'h21);
        tick();
        // stall 1: accepted into skid, M holds
        out_ready = 1'b0; drive(1'b1, 8'h22);
        n_cmp++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_stall1: got o=%0d r=%b want o=1 r=1", occupancy, in_ready);
        end
        tick();
        drive(1'b1, 8'h23);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_ctrl !== 8'h21
                || out_data !== mk_data(32'h21, 32'h22, 32'h23)) begin
                n_bad++;
                $display("FAIL bp_stall%0d: got o=%0d r=%b c=%h want o=2 r=0 c=21",
                         i + 2, occupancy, in_ready, out_ctrl);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid === 1'b1) seen.push_back(out_ctrl);
            if (in_ready === 1'b1 && in_valid === 1'b1 && in_ctrl == 8'h23) begin
                tick();
                drive(1'b0, 8'h00);
            end else begin
                tick();
            end
        end
        n_cmp++;
        if (seen.size() != 3 || seen[0] !== want[0] || seen[1] !== want[1] || seen[2] !== want[2]) begin
            n_bad++;
            $display("FAIL bp_order: got %0d words %p want 3 words 21 22 23", seen.size(), seen);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_bad++; $display("FAIL bp_empty: got v=%b o=%0d want v=0 o=0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; drive(1'b1, 8'h31);
        tick();
        drive(1'b1, 8'h32);
        tick();
        n_cmp++;
        if (occupancy !== 2'd2) begin
            n_bad++; $display("FAIL flush_fill: got o=%0d want 2", occupancy);
        end
        flush = 1'b1; drive(1'b1, 8'hFF);
        tick();
        flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_full: got v=%b c=%h o=%0d r=%b want v=0 c=00 o=0 r=1",
                     out_valid, out_ctrl, occupancy, in_ready);
        end
        // flush while ONE with an accept: the accepted word must vanish
        drive(1'b1, 8'h33);
        tick();
        flush = 1'b1; out_ready = 1'b1; drive(1'b1, 8'hFE);
        tick();
        flush = 1'b0; drive(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
                n_bad++;
                $display("FAIL flush_squash%0d: got v=%b c=%h want v=0 c=00", i, out_valid, out_ctrl);
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0; drive(1'b1, 8'h41);
        tick();
        drive(1'b1, 8'h42);
        tick();
        rst = 1'b1; drive(1'b1, 8'h43);
        tick();
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || bubble_cnt !== 16'd0
            || out_ctrl !== 8'h00 || out_data !== '0 || out_addr !== '0) begin
            n_bad++;
            $display("FAIL rst_full: got v=%b r=%b o=%0d b=%0d c=%h d=%h a=%h want all reset",
                     out_valid, in_ready, occupancy, bubble_cnt, out_ctrl, out_data, out_addr);
        end
        drive(1'b1, 8'h11);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_ctrl !== 8'h11 || occupancy !== 2'd1) begin
            n_bad++;
            $display("FAIL rst_accept: got v=%b c=%h o=%0d want v=1 c=11 o=1", out_valid, out_ctrl, occupancy);
        end
        out_ready = 1'b1; drive(1'b0, 8'h00);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || bubble_cnt !== 16'd0) begin
            n_bad++; $display("FAIL rst_alone: got v=%b b=%0d want v=0 b=0", out_valid, bubble_cnt);
        end
        tick();
        n_cmp++;
        if (bubble_cnt !== 16'd1) begin
            n_bad++; $display("FAIL rst_bubble: got %0d want 1", bubble_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want [6];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3;
        want[3] = 2'd3; want[4] = 2'd3; want[5] = 2'd3;
        rst2 = 1'b1; out_ready2 = 1'b1;
        tick();
        rst2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (bubble_cnt2 !== want[i]) begin
                n_bad++; $display("FAIL sat_cycle%0d: got %0d want %0d", i, bubble_cnt2, want[i]);
            end
        end
    endtask

    initial begin
        rst2 = 1'b1; out_ready2 = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_midflight();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic inter-stage pipeline register for the pipelined MIPS datapath (ID/EX, EX/MEM, MEM/WB).
- Carries a control vector, NUM_DATA data words and NUM_ADDR register addresses.
- Uses a valid/ready handshake, a 2-entry skid buffer for full-throughput backpressure, and a synchronous flush that squashes in-flight instructions into NOPs.
- Includes a saturating bubble counter for performance debug.

Parameters:
- CTRL_W, 8, control vector width
- NOP_CTRL, 0, control value driven when no valid instruction is presented (nop)
- DATA_W, 32, width of each data word
- NUM_DATA, 3, number of data words (e.g. sign-ext, rdata1, rdata2)
- ADDR_W, 5, register-address width
- NUM_ADDR, 3, number of register addresses (e.g. rs, rt, rd)
- CNT_W, 16, bubble counter width

Ports:
- clk, in, 1, clock; all state updates on the rising edge
- rst, in, 1, synchronous, active-high reset
- flush, in, 1, synchronous squash of all held entries
- in_valid, in, 1, upstream presents an instruction
- in_ready, out, 1, stage can accept; registered, not combinationally dependent on out_ready
- in_ctrl, in, CTRL_W, control vector
- in_data, in, NUM_DATA*DATA_W, packed data words; word k at [k*DATA_W +: DATA_W]
- in_addr, in, NUM_ADDR*ADDR_W, packed addresses; same packing rule
- out_valid, out, 1, stage presents an instruction
- out_ready, in, 1, downstream accepts
- out_ctrl, out, CTRL_W, control vector; equals NOP_CTRL whenever out_valid=0
- out_data, out, NUM_DATA*DATA_W, data words
- out_addr, out, NUM_ADDR*ADDR_W, addresses
- occupancy, out, 2, number of held entries (0..2)
- bubble_cnt, out, CNT_W, saturating count of bubble cycles

Behaviour:
- Accept event: in_valid && in_ready. Emit event: out_valid && out_ready.
- Storage: main register M (drives outputs) and skid register S. States EMPTY (0), ONE (M valid), FULL (M and S valid).
- Latency: a word accepted into EMPTY appears on outputs the next cycle. There is no combinational path from input to output.
- in_ready = (state != FULL), registered.
- EMPTY:
  - accept -> ONE (M <= input).
- ONE:
  - accept and emit -> ONE (M <= input).
  - accept, no emit -> FULL (S <= input).
  - emit, no accept -> EMPTY.
  - otherwise hold.
- FULL:
  - emit -> ONE (M <= S).
  - otherwise hold.
  - in_ready=0, so no accept occurs.
- Order is strictly FIFO. Input payload is captured only on accept; held payloads never change while waiting.
- out_valid=0 -> out_ctrl=NOP_CTRL. out_data and out_addr hold their last values (don't-care for consumers).
- flush=1:
  - Next cycle: state EMPTY, out_valid=0, out_ctrl=NOP_CTRL, in_ready=1.
  - An accept and/or emit in the flush cycle still completes as a handshake, but the accepted word is discarded.
- rst=1 (priority over flush) -> next cycle:
  - state EMPTY, out_valid=0, in_ready=1, occupancy=0, bubble_cnt=0
  - out_ctrl=NOP_CTRL, out_data=0, out_addr=0
  - M=S=0
- Reset asserted mid-transfer discards all entries. There is no output activity in the reset cycle's successor.
- bubble_cnt increments by 1 in each cycle with out_ready=1 && out_valid=0 && !rst. It saturates at 2^CNT_W-1 with no wrap. flush does not clear it.
- occupancy reflects the state: 0, 1 or 2.

Test Plan:
- Reset, then idle with out_ready=1 for 5 cycles -> out_valid=0, out_ctrl=8'h00, in_ready=1, bubble_cnt=5.
- Stream ctrl=8'hA5 with data words {1,2,3} and addrs {4,5,6}, then ctrl=8'h5A with words {7,8,9} and addrs {10,11,12}, on consecutive cycles, out_ready=1 -> each appears 1 cycle after accept, back-to-back, in order.
- Drop out_ready for 3 cycles during a continuous stream -> occupancy goes 1 then 2, in_ready=0 from the 2nd stall cycle. On release, all words are emitted in order; none are lost or duplicated.
- In FULL state, assert flush together with in_valid=1 (ctrl=8'hFF) -> next cycle out_valid=0, out_ctrl=8'h00, occupancy=0, in_ready=1; 8'hFF never appears on the outputs.
- Assert rst while FULL and out_ready=0 -> next cycle all outputs are at reset values; a subsequent accept of ctrl=8'h11 emerges alone.
- With CNT_W=2, hold out_ready=1 and no input for 6 cycles -> bubble_cnt reads 1, 2, 3, 3, 3, 3.
